hello_scroller: RTL and testbench

//  Upstream stage for the eight 3-bit-code 7-segment decoders (HEX7..HEX0).
//  - Holds an 8-character ring of 3-bit character codes, initialised to "HELLO   ".
//  - Rotates the ring one position per timebase tick, so the word scrolls across the displays.
//  - Each 3-bit slice of Chars drives one decoder instance.
//  - Codes: H=3'b000, E=3'b001, L=3'b010, O=3'b011, blank=BLANK_CODE (decoder shows all segments off).

---
 rtl/hello_scroller.sv | 55 +++++
 tb/tb_hello_scroller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hello_scroller.sv
// hello_scroller: scrolls "HELLO   " across eight 3-bit-code 7-segment decoders.
// Optional macro SCROLL_DIR_EN adds a dir_i port selecting right-rotation.
module hello_scroller #(
   parameter int         TICK_DIV   = 50000000,
   parameter logic [2:0] BLANK_CODE = 3'b111
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        run_i,
   input  logic        load_i,
`ifdef SCROLL_DIR_EN
   input  logic        dir_i,
`endif
   output logic [23:0] chars_o,
   output logic        tick_o,
   output logic [2:0]  phase_o
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [23:0] INIT = {3'b000, 3'b001, 3'b010, 3'b010, 3'b011,
                                   BLANK_CODE, BLANK_CODE, BLANK_CODE};
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   chars_q, chars_d;
   logic [2:0]    phase_q, phase_d;
   logic          tick_q, step, dir;
`ifdef SCROLL_DIR_EN
   assign dir = dir_i;
`else
   assign dir = 1'b0;
`endif
   // Left rotation moves the leftmost character (HEX7) into HEX0.
   always_comb begin
      step    = run_i && (cnt_q == CNT_MAX);
      cnt_d   = !run_i ? cnt_q : step ? '0 : cnt_q + CW'(1);
      chars_d = !step ? chars_q : dir ? {chars_q[2:0], chars_q[23:3]}
                                      : {chars_q[20:0], chars_q[23:21]};
      phase_d = !step ? phase_q : dir ? phase_q - 3'd1 : phase_q + 3'd1;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i || load_i) begin
         cnt_q   <= '0;
         chars_q <= INIT;
         phase_q <= 3'd0;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         chars_q <= chars_d;
         phase_q <= phase_d;
         tick_q  <= step;
      end
   end
   assign chars_o = chars_q;
   assign tick_o  = tick_q;
   assign phase_o = phase_q;
endmodule

// File: tb/tb_hello_scroller.sv
// tb_hello_scroller: checks TICK_DIV=4 and TICK_DIV=1 instances against a run-count model.
// Define SCROLL_DIR_EN for both RTL and bench to exercise right-rotation.
module tb_hello_scroller;
   logic clk = 1'b0, rst = 1'b1, run = 1'b0, load = 1'b0, dir = 1'b0;
   logic [23:0] chars4, chars1;
   logic tick4, tick1;
   logic [2:0] phase4, phase1;
   int tests = 0, fails = 0;
   int div[2] = '{4, 1};
   int rc[2], pos[2];
   logic tk[2];
   localparam logic [23:0] INIT = 24'o01223777;

   always #5 clk = ~clk;

   hello_scroller #(.TICK_DIV(4), .BLANK_CODE(3'b111)) dut4 (
      .clk_i(clk), .rst_i(rst), .run_i(run), .load_i(load),
`ifdef SCROLL_DIR_EN
      .dir_i(dir),
`endif
      .chars_o(chars4), .tick_o(tick4), .phase_o(phase4));

   hello_scroller #(.TICK_DIV(1), .BLANK_CODE(3'b111)) dut1 (
      .clk_i(clk), .rst_i(rst), .run_i(run), .load_i(load),
`ifdef SCROLL_DIR_EN
      .dir_i(dir),
`endif
      .chars_o(chars1), .tick_o(tick1), .phase_o(phase1));

   // Message shown after a net of p left-steps from the initial text.
   function automatic logic [23:0] shown(input int p);
      logic [23:0] v = INIT;
      for (int i = 0; i < p; i++) v = {v[20:0], v[23:21]};
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic ru, input logic ld, input logic dr);
      logic d;
      rst = r; run = ru; load = ld; dir = dr;
`ifdef SCROLL_DIR_EN
      d = dr;
`else
      d = 1'b0;
`endif
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         tk[k] = 1'b0;
         if (r || ld) begin
            rc[k] = 0; pos[k] = 0;
         end else if (ru) begin
            rc[k]++;
            if (rc[k] == div[k]) begin
               rc[k] = 0;
               pos[k] = (pos[k] + (d ? 7 : 1)) % 8;
               tk[k] = 1'b1;
            end
         end
      end
      #1;
      chk("chars4", 32'(chars4), 32'(shown(pos[0])));
      chk("tick4",  32'(tick4),  32'(tk[0]));
      chk("phase4", 32'(phase4), 32'(pos[0]));
      chk("chars1", 32'(chars1), 32'(shown(pos[1])));
      chk("tick1",  32'(tick1),  32'(tk[1]));
      chk("phase1", 32'(phase1), 32'(pos[1]));
   endtask

   initial begin
      // Reset for two clocks
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("reset_chars", 32'(chars4), 32'(24'o01223777));
      chk("reset_tick",  32'(tick4), 32'd0);
      chk("reset_phase", 32'(phase4), 32'd0);
      // First step after exactly four run cycles
      repeat (3) cyc(0, 1, 0, 0);
      chk("no_early_step", 32'(chars4), 32'(24'o01223777));
      cyc(0, 1, 0, 0);
      chk("first_step_chars", 32'(chars4), 32'(24'o12237770));
      chk("first_step_tick",  32'(tick4), 32'd1);
      chk("first_step_phase", 32'(phase4), 32'd1);
      // Full wrap from a fresh reset
      cyc(1, 0, 0, 0);
      repeat (32) cyc(0, 1, 0, 0);
      chk("wrap_chars", 32'(chars4), 32'(INIT));
      chk("wrap_phase", 32'(phase4), 32'd0);
      // Pause mid-count then resume
      cyc(1, 0, 0, 0);
      repeat (2) cyc(0, 1, 0, 0);
      repeat (10) cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk("resume_no_step", 32'(phase4), 32'd0);
      cyc(0, 1, 0, 0);
      chk("resume_step", 32'(phase4), 32'd1);
      // Load coincident with a step
      cyc(1, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      chk("load_chars", 32'(chars4), 32'(INIT));
      chk("load_tick",  32'(tick4), 32'd0);
      chk("load_phase", 32'(phase4), 32'd0);
      repeat (3) cyc(0, 1, 0, 0);
      chk("load_cnt_cleared", 32'(tick4), 32'd0);
      cyc(0, 1, 0, 0);
      chk("load_then_step", 32'(tick4), 32'd1);
`ifdef SCROLL_DIR_EN
      // Right rotation
      cyc(1, 0, 0, 0);
      repeat (4) cyc(0, 1, 0, 1);
      chk("right_chars", 32'(chars4), 32'(24'o70122377));
      chk("right_phase", 32'(phase4), 32'd7);
`endif
      // Randomized run/load/reset/dir traffic
      repeat (400)
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
